vending_ctrl_param: RTL and testbench
=====================================

Name: vending_ctrl_param

Overview:
- Parametrised coin-operated vend controller, successor to the fixed 4-quarter vending FSM.
- Accumulates credit in 25-unit quanta against a configurable price and pulses a product enable.
- Returns change, supports a user cancel, and refunds credit after a configurable inactivity timeout.
- Sits between the coin-acceptor decoder and the dispense/change-hopper drivers.

Parameters:
- PRICE, 4, product price in quarters (25-unit quanta); legal range 1..255.
- TIMEOUT_CYC, 1280, idle cycles in COLLECT before automatic refund; must be >= 2.
- CREDIT_W, 9, credit/change width in quarters; must hold PRICE+3.
- TMR_W, 11, inactivity timer width; must hold TIMEOUT_CYC-1.

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- coin  input  2  coin code: 00=25 (1q), 01=50 (2q), 10=100 (4q), 11=no coin; sampled every rising edge.
- cancel  input  1  level, sampled each edge; request refund of held credit.
- pr_en  output  1  one-cycle product-dispense pulse.
- chg_valid  output  1  one-cycle pulse; chg_q is valid while high.
- chg_q  output  CREDIT_W  change/refund amount in quarters; 0 when chg_valid=0.
- refund  output  1  one-cycle pulse, high with chg_valid on cancel/timeout refunds.
- coin_reject  output  1  one-cycle pulse for a coin presented in VEND or REFUND.
- credit  output  CREDIT_W  current held credit in quarters (registered).
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE; credit=0; timer=0; all pulse outputs 0; chg_q=0.
- Reset asserted mid-transaction discards the held credit. There is no refund pulse.
- States and transitions:
  - IDLE: a valid coin adds its value to credit and moves to COLLECT. If credit+coin >= PRICE, go straight to VEND. cancel is ignored.
  - COLLECT: a valid coin adds its value to credit. If the new credit >= PRICE, go to VEND on the same edge (credit register holds the new total). A coin edge with cancel=1 moves to REFUND with the coin already included. With no coin and cancel=1, move to REFUND. With no coin and timer==TIMEOUT_CYC-1, move to REFUND.
  - VEND (exactly 1 cycle): pr_en=1, chg_valid=1, chg_q=credit-PRICE (may be 0). Next edge: credit=0, state=IDLE.
  - REFUND (exactly 1 cycle): refund=1, chg_valid=1, chg_q=credit. Next edge: credit=0, state=IDLE.
- Latency: the coin completing the price is sampled at edge N; pr_en is high during cycle N..N+1. This is one-cycle registered latency.
- Coins in VEND/REFUND: not credited; coin_reject=1 during the following cycle; no state effect.
- Inactivity timer:
  - Counts only in COLLECT with coin==11 and cancel=0.
  - Cleared on every accepted coin and on entry to COLLECT.
  - Held at 0 outside COLLECT.
  - Timeout fires on the edge where timer==TIMEOUT_CYC-1 and no coin is present. A coin on that edge wins, and the timer clears.
- Arithmetic:
  - Credit addition is unsigned, CREDIT_W wide.
  - The maximum reachable credit is PRICE+3 (PRICE-1 plus a 4q coin), so no overflow occurs by construction.
  - Change is credit-PRICE, always >= 0 in VEND.
- Outputs pr_en, chg_valid, refund, coin_reject and chg_q are registered, with no combinational path from input to output.

Decomposition:
- Package vending_pkg holds:
  - coin code constants COIN_25, COIN_50, COIN_100, COIN_NONE;
  - the 2-bit state typedef (IDLE, COLLECT, VEND, REFUND);
  - a function coin_value(coin) returning quarters (0 for COIN_NONE).
- Sub-module vend_idle_timer: parameter TIMEOUT_CYC, TMR_W; inputs clk, reset, run, clear; output expire. Top FSM instantiates one.

Test Plan (PRICE=4, TIMEOUT_CYC=16 unless stated):
- Exact pay: coin 00,00,00,00 on consecutive edges -> after 4th edge pr_en=1 for 1 cycle, chg_q=0, chg_valid=1, credit returns to 0, state IDLE.
- Overpay: 01 then 10 -> VEND cycle with pr_en=1, chg_q=2; a coin 00 presented during VEND -> coin_reject=1 next cycle, credit stays 0.
- Single 100 coin from IDLE -> VEND directly after one edge, pr_en=1, chg_q=0.
- Cancel: 00,01 then cancel=1 -> REFUND cycle with refund=1, chg_q=3, pr_en=0; cancel in IDLE -> no outputs.
- Timeout: coin 00 then coin=11 for 16 cycles -> refund=1, chg_q=1 on the 16th idle edge; repeat with coin 00 on the 15th idle edge -> no refund, timer restarts, credit=2.
- Reset mid-COLLECT (credit=3) -> next cycle credit=0, busy=0, no pr_en/refund pulse; PRICE=7 run: 10,10 -> pr_en, chg_q=1.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared coin encodings, FSM state type and coin valuation for the vend controller.
package vending_pkg;

  localparam logic [1:0] COIN_25   = 2'b00;
  localparam logic [1:0] COIN_50   = 2'b01;
  localparam logic [1:0] COIN_100  = 2'b10;
  localparam logic [1:0] COIN_NONE = 2'b11;

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, REFUND} state_t;

  // Coin value in quarters; COIN_NONE is worth nothing.
  function automatic logic [2:0] coin_value(input logic [1:0] coin);
    case (coin)
      COIN_25:  return 3'd1;
      COIN_50:  return 3'd2;
      COIN_100: return 3'd4;
      default:  return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_idle_timer.sv
// Inactivity timer: counts while run is high, flags the last cycle before refund.
module vend_idle_timer #(
  parameter int TIMEOUT_CYC = 1280,
  parameter int TMR_W       = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] timer;

  assign expire = (timer == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      timer <= '0;
    end else if (run) begin
      timer <= expire ? '0 : timer + TMR_W'(1);
    end
  end

endmodule

// File: rtl/vending_ctrl_param.sv
// Parametrised vend controller: accumulates credit, vends at PRICE, refunds on
// cancel or inactivity timeout. All pulse outputs and chg_q are registered.
module vending_ctrl_param
  import vending_pkg::*;
#(
  parameter int PRICE       = 4,
  parameter int TIMEOUT_CYC = 1280,
  parameter int CREDIT_W    = 9,
  parameter int TMR_W       = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic                cancel,
  output logic                pr_en,
  output logic                chg_valid,
  output logic [CREDIT_W-1:0] chg_q,
  output logic                refund,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt, chg_nxt, sum;
  logic                pr_nxt, chgv_nxt, refund_nxt, reject_nxt;
  logic                coin_present, tmr_run, tmr_expire;

  assign coin_present = (coin != COIN_NONE);
  assign sum          = credit + CREDIT_W'(coin_value(coin));
  assign tmr_run      = (state == COLLECT) && !coin_present && !cancel;
  assign busy         = (state != IDLE);

  vend_idle_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TMR_W      (TMR_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .run   (tmr_run),
    .clear (!tmr_run),
    .expire(tmr_expire)
  );

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    pr_nxt     = 1'b0;
    chgv_nxt   = 1'b0;
    refund_nxt = 1'b0;
    reject_nxt = 1'b0;
    chg_nxt    = '0;
    case (state)
      IDLE: begin
        if (coin_present) begin
          credit_nxt = sum;
          state_nxt  = (sum >= PRICE_C) ? VEND : COLLECT;
        end
      end
      COLLECT: begin
        if (coin_present) begin
          credit_nxt = sum;
          if (sum >= PRICE_C)  state_nxt = VEND;
          else if (cancel)     state_nxt = REFUND;
        end else if (cancel || tmr_expire) begin
          state_nxt = REFUND;
        end
      end
      default: begin
        state_nxt  = IDLE;
        credit_nxt = '0;
        reject_nxt = coin_present;
      end
    endcase
    // Pulses are registered, so they are decoded from the state being entered.
    case (state_nxt)
      VEND: begin
        pr_nxt   = 1'b1;
        chgv_nxt = 1'b1;
        chg_nxt  = credit_nxt - PRICE_C;
      end
      REFUND: begin
        refund_nxt = 1'b1;
        chgv_nxt   = 1'b1;
        chg_nxt    = credit_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      credit      <= '0;
      pr_en       <= 1'b0;
      chg_valid   <= 1'b0;
      chg_q       <= '0;
      refund      <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      pr_en       <= pr_nxt;
      chg_valid   <= chgv_nxt;
      chg_q       <= chg_nxt;
      refund      <= refund_nxt;
      coin_reject <= reject_nxt;
    end
  end

endmodule

// File: tb/tb_vending_ctrl_param.sv
// Bench for vending_ctrl_param: PRICE=4 instance scoreboarded on change events,
// plus a PRICE=7 instance for the parameter override.
module tb_vending_ctrl_param;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] coin_a, coin_b;
  logic       cancel_a, cancel_b;
  logic       pr_en_a, chg_valid_a, refund_a, coin_reject_a, busy_a;
  logic       pr_en_b, chg_valid_b, refund_b, coin_reject_b, busy_b;
  logic [8:0] chg_q_a, credit_a, chg_q_b, credit_b;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  typedef struct packed {
    logic       pr;
    logic       rf;
    logic [8:0] chg;
  } ev_t;

  ev_t exp_q[$];

  always #5 clk = ~clk;

  vending_ctrl_param #(.PRICE(4), .TIMEOUT_CYC(16), .CREDIT_W(9), .TMR_W(11)) dut_a (
    .clk(clk), .reset(reset), .coin(coin_a), .cancel(cancel_a),
    .pr_en(pr_en_a), .chg_valid(chg_valid_a), .chg_q(chg_q_a), .refund(refund_a),
    .coin_reject(coin_reject_a), .credit(credit_a), .busy(busy_a)
  );

  vending_ctrl_param #(.PRICE(7), .TIMEOUT_CYC(16), .CREDIT_W(9), .TMR_W(11)) dut_b (
    .clk(clk), .reset(reset), .coin(coin_b), .cancel(cancel_b),
    .pr_en(pr_en_b), .chg_valid(chg_valid_b), .chg_q(chg_q_b), .refund(refund_b),
    .coin_reject(coin_reject_b), .credit(credit_b), .busy(busy_b)
  );

  // Scoreboard: every chg_valid pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk_cnt++;
      if (chg_valid_a === 1'b1) begin
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected: got pr=%b rf=%b chg=%0d, required no change event",
                   pr_en_a, refund_a, chg_q_a);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if ({pr_en_a, refund_a, chg_q_a} !== e)
            $display("FAIL sb_event: got pr=%b rf=%b chg=%0d, required pr=%b rf=%b chg=%0d",
                     pr_en_a, refund_a, chg_q_a, e.pr, e.rf, e.chg);
          else pass_cnt++;
        end
      end else begin
        if ({chg_valid_a, pr_en_a, refund_a, chg_q_a} !== 12'd0)
          $display("FAIL sb_quiet: got cv=%b pr=%b rf=%b chg=%0d, required all 0",
                   chg_valid_a, pr_en_a, refund_a, chg_q_a);
        else pass_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [1:0] c, input logic cn);
    coin_a   = c;
    cancel_a = cn;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; coin_a = 2'b11; cancel_a = 1'b0; coin_b = 2'b11; cancel_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if ({credit_a, busy_a, pr_en_a, chg_valid_a, chg_q_a, refund_a, coin_reject_a} !== 23'd0)
      $display("FAIL reset_a: got credit=%0d busy=%b pr=%b cv=%b chg=%0d rf=%b rej=%b, required all 0",
               credit_a, busy_a, pr_en_a, chg_valid_a, chg_q_a, refund_a, coin_reject_a);
    else pass_cnt++;
    chk_cnt++;
    if ({credit_b, busy_b, pr_en_b, chg_valid_b} !== 12'd0)
      $display("FAIL reset_b: got credit=%0d busy=%b pr=%b cv=%b, required all 0",
               credit_b, busy_b, pr_en_b, chg_valid_b);
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_exact_pay();
    exp_q.push_back('{pr: 1'b1, rf: 1'b0, chg: 9'd0});
    repeat (3) drive(2'b00, 1'b0);
    chk_cnt++;
    if ({busy_a, credit_a, pr_en_a} !== {1'b1, 9'd3, 1'b0})
      $display("FAIL exact_collect: got busy=%b credit=%0d pr=%b, required 1/3/0", busy_a, credit_a, pr_en_a);
    else pass_cnt++;
    drive(2'b00, 1'b0);
    chk_cnt++;
    if ({pr_en_a, credit_a} !== {1'b1, 9'd4})
      $display("FAIL exact_vend: got pr=%b credit=%0d, required 1/4", pr_en_a, credit_a);
    else pass_cnt++;
    drive(2'b11, 1'b0);
    chk_cnt++;
    if ({pr_en_a, busy_a, credit_a} !== 11'd0)
      $display("FAIL exact_after: got pr=%b busy=%b credit=%0d, required 0/0/0", pr_en_a, busy_a, credit_a);
    else pass_cnt++;
  endtask

  task automatic test_overpay_reject();
    exp_q.push_back('{pr: 1'b1, rf: 1'b0, chg: 9'd2});
    drive(2'b01, 1'b0);
    drive(2'b10, 1'b0);
    chk_cnt++;
    if ({pr_en_a, credit_a} !== {1'b1, 9'd6})
      $display("FAIL overpay_vend: got pr=%b credit=%0d, required 1/6", pr_en_a, credit_a);
    else pass_cnt++;
    drive(2'b00, 1'b0);
    chk_cnt++;
    if ({coin_reject_a, credit_a, busy_a} !== {1'b1, 9'd0, 1'b0})
      $display("FAIL reject_vend: got rej=%b credit=%0d busy=%b, required 1/0/0", coin_reject_a, credit_a, busy_a);
    else pass_cnt++;
    drive(2'b11, 1'b0);
    chk_cnt++;
    if ({coin_reject_a, credit_a} !== 10'd0)
      $display("FAIL reject_clear: got rej=%b credit=%0d, required 0/0", coin_reject_a, credit_a);
    else pass_cnt++;
  endtask

  task automatic test_single_100();
    exp_q.push_back('{pr: 1'b1, rf: 1'b0, chg: 9'd0});
    drive(2'b10, 1'b0);
    chk_cnt++;
    if ({pr_en_a, credit_a, busy_a} !== {1'b1, 9'd4, 1'b1})
      $display("FAIL single100: got pr=%b credit=%0d busy=%b, required 1/4/1", pr_en_a, credit_a, busy_a);
    else pass_cnt++;
    drive(2'b11, 1'b0);
  endtask

  task automatic test_cancel();
    exp_q.push_back('{pr: 1'b0, rf: 1'b1, chg: 9'd3});
    drive(2'b00, 1'b0);
    drive(2'b01, 1'b0);
    drive(2'b11, 1'b1);
    chk_cnt++;
    if ({refund_a, pr_en_a, credit_a} !== {1'b1, 1'b0, 9'd3})
      $display("FAIL cancel_refund: got rf=%b pr=%b credit=%0d, required 1/0/3", refund_a, pr_en_a, credit_a);
    else pass_cnt++;
    drive(2'b11, 1'b0);
    drive(2'b11, 1'b1);
    chk_cnt++;
    if ({busy_a, credit_a, refund_a} !== 11'd0)
      $display("FAIL cancel_idle: got busy=%b credit=%0d rf=%b, required 0/0/0", busy_a, credit_a, refund_a);
    else pass_cnt++;
    // Coin together with cancel: refund includes that coin.
    exp_q.push_back('{pr: 1'b0, rf: 1'b1, chg: 9'd3});
    drive(2'b00, 1'b0);
    drive(2'b01, 1'b1);
    chk_cnt++;
    if ({refund_a, credit_a} !== {1'b1, 9'd3})
      $display("FAIL cancel_coin: got rf=%b credit=%0d, required 1/3", refund_a, credit_a);
    else pass_cnt++;
    drive(2'b11, 1'b0);
  endtask

  task automatic test_timeout();
    exp_q.push_back('{pr: 1'b0, rf: 1'b1, chg: 9'd1});
    drive(2'b00, 1'b0);
    repeat (15) drive(2'b11, 1'b0);
    chk_cnt++;
    if ({busy_a, refund_a} !== 2'b10)
      $display("FAIL timeout_early: got busy=%b rf=%b, required 1/0", busy_a, refund_a);
    else pass_cnt++;
    drive(2'b11, 1'b0);
    chk_cnt++;
    if ({refund_a, chg_q_a} !== {1'b1, 9'd1})
      $display("FAIL timeout_fire: got rf=%b chg=%0d, required 1/1", refund_a, chg_q_a);
    else pass_cnt++;
    drive(2'b11, 1'b0);
    // Coin on the 15th idle edge restarts the timer.
    drive(2'b00, 1'b0);
    repeat (14) drive(2'b11, 1'b0);
    drive(2'b00, 1'b0);
    repeat (15) drive(2'b11, 1'b0);
    chk_cnt++;
    if ({busy_a, credit_a, refund_a} !== {1'b1, 9'd2, 1'b0})
      $display("FAIL timeout_restart: got busy=%b credit=%0d rf=%b, required 1/2/0", busy_a, credit_a, refund_a);
    else pass_cnt++;
    exp_q.push_back('{pr: 1'b0, rf: 1'b1, chg: 9'd2});
    drive(2'b11, 1'b0);
    drive(2'b11, 1'b0);
    // Coin on the expiry edge wins over the timeout.
    drive(2'b00, 1'b0);
    repeat (15) drive(2'b11, 1'b0);
    drive(2'b00, 1'b0);
    chk_cnt++;
    if ({busy_a, credit_a, refund_a} !== {1'b1, 9'd2, 1'b0})
      $display("FAIL timeout_coin_wins: got busy=%b credit=%0d rf=%b, required 1/2/0", busy_a, credit_a, refund_a);
    else pass_cnt++;
    exp_q.push_back('{pr: 1'b0, rf: 1'b1, chg: 9'd2});
    drive(2'b11, 1'b1);
    drive(2'b11, 1'b0);
  endtask

  task automatic test_reset_mid();
    drive(2'b00, 1'b0);
    drive(2'b01, 1'b0);
    chk_cnt++;
    if (credit_a !== 9'd3)
      $display("FAIL mid_credit: got credit=%0d, required 3", credit_a);
    else pass_cnt++;
    reset = 1'b1;
    drive(2'b11, 1'b0);
    reset = 1'b0;
    chk_cnt++;
    if ({credit_a, busy_a, pr_en_a, refund_a, chg_valid_a} !== 13'd0)
      $display("FAIL mid_reset: got credit=%0d busy=%b pr=%b rf=%b cv=%b, required all 0",
               credit_a, busy_a, pr_en_a, refund_a, chg_valid_a);
    else pass_cnt++;
    drive(2'b11, 1'b0);
  endtask

  task automatic test_price7();
    coin_b = 2'b10;
    @(posedge clk); #1;
    chk_cnt++;
    if ({busy_b, credit_b, pr_en_b} !== {1'b1, 9'd4, 1'b0})
      $display("FAIL p7_collect: got busy=%b credit=%0d pr=%b, required 1/4/0", busy_b, credit_b, pr_en_b);
    else pass_cnt++;
    @(posedge clk); #1;
    coin_b = 2'b11;
    chk_cnt++;
    if ({pr_en_b, chg_valid_b, chg_q_b, refund_b} !== {1'b1, 1'b1, 9'd1, 1'b0})
      $display("FAIL p7_vend: got pr=%b cv=%b chg=%0d rf=%b, required 1/1/1/0", pr_en_b, chg_valid_b, chg_q_b, refund_b);
    else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if ({pr_en_b, credit_b, busy_b} !== 11'd0)
      $display("FAIL p7_after: got pr=%b credit=%0d busy=%b, required 0/0/0", pr_en_b, credit_b, busy_b);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_exact_pay();
    test_overpay_reject();
    test_single_100();
    test_cancel();
    test_timeout();
    test_reset_mid();
    test_price7();
    drive(2'b11, 1'b0);
    chk_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL sb_drain: got %0d pending events, required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
